// File: rtl/arb_rr_mc.sv
// Output-port arbiter with multicast and unicast request classes. Each class has its own
// round-robin pointer, the grant is locked until the owner's tail flit leaves, and a
// starvation guard stops multicast from blocking unicast indefinitely.
module arb_rr_mc #(
  parameter int unsigned N          = 5,
  parameter bit          RR_EN      = 1'b1,
  parameter bit          MC_STRICT  = 1'b0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] u_req_i,
  input  logic [N-1:0] m_req_i,
  input  logic [N-1:0] multab_ct_i,
  input  logic [N-1:0] release_i,
  output logic [N-1:0] grt_o,
  output logic         grt_mc_o,
  output logic         busy_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e         state_q;
  logic [N-1:0]   grt_q, grt_d;
  logic           grt_mc_q;
  logic [PW-1:0]  ptr_u_q, ptr_m_q, ptr_d;
  logic [SW-1:0]  starve_q, starve_d;

  logic [N-1:0]   em, eu, win_vec;
  logic           mc_block, force_u, arb_en, win_mc, win_u, win_found;
  logic [PW-1:0]  win_start, win_idx;
  logic [PW:0]    scan_idx;

  assign em       = m_req_i & ~multab_ct_i;
  assign eu       = u_req_i;
  assign mc_block = MC_STRICT ? |m_req_i : |em;
  assign force_u  = (STARVE_MAX != 0) && (starve_q == SW'(STARVE_MAX)) && |eu;
  assign win_mc   = mc_block && |em && !force_u;
  assign win_u    = |eu && (!mc_block || force_u);

  // A new arbitration runs when idle, or in the same cycle the owner's tail leaves.
  assign arb_en   = (state_q == StIdle) || |(grt_q & release_i);

  assign win_vec   = win_mc ? em : eu;
  assign win_start = !RR_EN ? '0 : (win_mc ? ptr_m_q : ptr_u_q);

  // Scan upward from the pointer, wrapping modulo N so no index >= N is ever used.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = {1'b0, win_start} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(N)) begin
        scan_idx = scan_idx - (PW+1)'(N);
      end
      if (!win_found && win_vec[scan_idx[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    grt_d    = N'(1) << win_idx;
    ptr_d    = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
    starve_d = '0;
    if (win_mc && |eu) begin
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      grt_q    <= '0;
      grt_mc_q <= 1'b0;
      ptr_u_q  <= '0;
      ptr_m_q  <= '0;
      starve_q <= '0;
    end else if (arb_en) begin
      if ((win_mc || win_u) && win_found) begin
        state_q  <= StLocked;
        grt_q    <= grt_d;
        grt_mc_q <= win_mc;
        starve_q <= starve_d;
        if (RR_EN) begin
          if (win_mc) ptr_m_q <= ptr_d;
          else        ptr_u_q <= ptr_d;
        end
      end else begin
        state_q  <= StIdle;
        grt_q    <= '0;
        grt_mc_q <= 1'b0;
      end
    end
  end

  assign grt_o    = grt_q;
  assign grt_mc_o = grt_mc_q;
  assign busy_o   = (state_q == StLocked);

endmodule

// File: tb/tb_arb_rr_mc.sv
// Bench for arb_rr_mc: two configurations driven in parallel, checked every cycle against
// an owner/pointer level model, plus directed literal expectations.
module tb_arb_rr_mc;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] u_req = '0, m_req = '0, mct = '0, rel = '0;
  logic [N-1:0] grt0, grt1;
  logic         mc0, mc1, busy0, busy1;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state per instance: owner index (-1 when idle), class, pointers, starvation count.
  int owner [2] = '{-1, -1};
  bit mdl_mc[2] = '{1'b0, 1'b0};
  int ptr_u [2] = '{0, 0};
  int ptr_m [2] = '{0, 0};
  int starve[2] = '{0, 0};

  always #5 clk = ~clk;

  arb_rr_mc #(.N(N), .RR_EN(1'b1), .MC_STRICT(1'b0), .STARVE_MAX(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .u_req_i(u_req), .m_req_i(m_req), .multab_ct_i(mct),
    .release_i(rel), .grt_o(grt0), .grt_mc_o(mc0), .busy_o(busy0)
  );

  arb_rr_mc #(.N(N), .RR_EN(1'b0), .MC_STRICT(1'b1), .STARVE_MAX(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .u_req_i(u_req), .m_req_i(m_req), .multab_ct_i(mct),
    .release_i(rel), .grt_o(grt1), .grt_mc_o(mc1), .busy_o(busy1)
  );

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (start + i) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input int k);
    bit rr, strict, arb, blk, fu;
    int smax, w;
    logic [N-1:0] em;
    rr     = (k == 0);
    strict = (k == 1);
    smax   = (k == 0) ? 4 : 2;
    if (rst) begin
      owner[k] = -1; mdl_mc[k] = 1'b0; ptr_u[k] = 0; ptr_m[k] = 0; starve[k] = 0;
      return;
    end
    arb = (owner[k] < 0) || rel[owner[k]];
    if (!arb) return;
    em  = m_req & ~mct;
    blk = strict ? (m_req != 0) : (em != 0);
    fu  = (smax != 0) && (starve[k] == smax) && (u_req != 0);
    if (blk && em != 0 && !fu) begin
      w = pick(em, rr ? ptr_m[k] : 0);
      owner[k] = w; mdl_mc[k] = 1'b1;
      if (rr) ptr_m[k] = (w + 1) % N;
      starve[k] = (u_req != 0) ? ((starve[k] < smax) ? starve[k] + 1 : smax) : 0;
    end else if (u_req != 0 && (!blk || fu)) begin
      w = pick(u_req, rr ? ptr_u[k] : 0);
      owner[k] = w; mdl_mc[k] = 1'b0;
      if (rr) ptr_u[k] = (w + 1) % N;
      starve[k] = 0;
    end else begin
      owner[k] = -1; mdl_mc[k] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp_model(input int k, input logic [N-1:0] g, input logic mc, input logic b);
    logic [N-1:0] eg;
    eg = (owner[k] < 0) ? '0 : N'(1) << owner[k];
    n_cmp++;
    if (g !== eg || mc !== mdl_mc[k] || b !== (owner[k] >= 0)) begin
      n_fail++;
      $display("FAIL model_inst%0d t=%0t: got grt=%b mc=%b busy=%b, want grt=%b mc=%b busy=%b",
               k, $time, g, mc, b, eg, mdl_mc[k], owner[k] >= 0);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_model(0, grt0, mc0, busy0);
      cmp_model(1, grt1, mc1, busy1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int k, input logic [N-1:0] eg,
                     input logic emc, input logic eb);
    logic [N-1:0] g;
    logic mc, b;
    g  = (k == 0) ? grt0 : grt1;
    mc = (k == 0) ? mc0 : mc1;
    b  = (k == 0) ? busy0 : busy1;
    n_cmp++;
    if (g !== eg || mc !== emc || b !== eb) begin
      n_fail++;
      $display("FAIL %s: got grt=%b mc=%b busy=%b, want grt=%b mc=%b busy=%b",
               name, g, mc, b, eg, emc, eb);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; u_req = '0; m_req = '0; mct = '0; rel = '0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] seq_g [6];
    logic         seq_m [6];
    cyc();
    do_reset();
    chk_en = 1'b1;
    chk("reset", 0, 5'b00000, 1'b0, 1'b0);

    // Single-cycle unicast packets rotate through the requesters.
    u_req = 5'b10110; rel = '1;
    cyc(); chk("rr_u_0", 0, 5'b00010, 1'b0, 1'b1);
    cyc(); chk("rr_u_1", 0, 5'b00100, 1'b0, 1'b1);
    cyc(); chk("rr_u_2", 0, 5'b10000, 1'b0, 1'b1);
    cyc(); chk("rr_u_3", 0, 5'b00010, 1'b0, 1'b1);

    do_reset();
    u_req = 5'b00001; m_req = 5'b01000;
    cyc(); chk("mc_first", 0, 5'b01000, 1'b1, 1'b1);
    m_req = '0; rel = '1;
    cyc(); chk("u_after_mc", 0, 5'b00001, 1'b0, 1'b1);

    // Masked multicast: relaxed mode serves unicast, legacy strict mode stalls.
    do_reset();
    u_req = 5'b00010; m_req = 5'b00100; mct = 5'b00100;
    cyc();
    chk("masked_mc_relaxed", 0, 5'b00010, 1'b0, 1'b1);
    chk("masked_mc_strict", 1, 5'b00000, 1'b0, 1'b0);

    do_reset();
    m_req = 5'b00011; u_req = 5'b10000; rel = '1;
    seq_g = '{5'b00001, 5'b00010, 5'b00001, 5'b00010, 5'b10000, 5'b00001};
    seq_m = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cyc(); chk($sformatf("starve_%0d", i), 0, seq_g[i], seq_m[i], 1'b1);
    end

    // Grant held through request drop and non-owner releases.
    do_reset();
    u_req = 5'b00100;
    cyc(); chk("lock_grant", 0, 5'b00100, 1'b0, 1'b1);
    u_req = 5'b00011; rel = 5'b01001;
    cyc(); chk("lock_hold_0", 0, 5'b00100, 1'b0, 1'b1);
    rel = '0;
    cyc(); chk("lock_hold_1", 0, 5'b00100, 1'b0, 1'b1);
    u_req = 5'b01011; rel = 5'b00100;
    cyc(); chk("lock_rearb_ptr3", 0, 5'b01000, 1'b0, 1'b1);

    do_reset();
    u_req = 5'b00100;
    cyc(); chk("pre_rst_grant", 0, 5'b00100, 1'b0, 1'b1);
    rst = 1'b1; rel = 5'b00100;
    cyc(); chk("rst_beats_release", 0, 5'b00000, 1'b0, 1'b0);
    rst = 1'b0; rel = '0; u_req = 5'b10100;
    cyc(); chk("ptr_cleared", 0, 5'b00100, 1'b0, 1'b1);

    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 127) == 0);
      u_req = N'($urandom) & N'($urandom);
      m_req = N'($urandom) & N'($urandom);
      mct   = N'($urandom) & N'($urandom) & N'($urandom);
      rel   = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
      cyc();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
